display_scan_driver: RTL
========================

# display_scan_driver

Downstream display stage of the 8-bit computer's output path. It captures the 8-bit value latched by the output register and converts it to three BCD digits with a sequential double-dabble engine, one bit per clock. It then time-multiplexes those digits onto a four-position common-anode seven-segment display. Conversion and display scanning run independently, so the display never blanks or glitches while a conversion is in progress.

## Interface
- REFRESH_DIV, default 50000: clock cycles each digit position stays lit; legal range 2..65535.
- clk  input  1  system clock; all logic on rising edge.
- clear_n  input  1  synchronous, active-low reset.
- load  input  1  capture `value` and start a conversion.
- value  input  8  unsigned binary value from the output register.
- busy  output  1  conversion in progress.
- digit  output  7  segments {g,f,e,d,c,b,a}, active-low (0 = lit).
- display  output  4  anode select, one-hot active-low; bit0 = ones, bit1 = tens, bit2 = hundreds, bit3 = unused position.

## Operation
- Reset values (clear_n low at an edge):
  - busy = 0, digit = 7'h7F, display = 4'hF.
  - Committed BCD = 000, scan index = 0, refresh counter = 0, FSM = IDLE.
  - Reset wins over load on the same edge; a conversion in progress is aborted and its partial result discarded.
- Conversion FSM, states IDLE, SHIFT, DONE:
  - IDLE: load = 1 sets the 20-bit shift register to {12'b0, value}, sets the iteration count to 0, moves to SHIFT, and sets busy = 1.
  - SHIFT: each cycle adds 3 to each BCD nibble ([19:16], [15:12], [11:8]) that is ≥5, then shifts the whole register left by 1. This is one registered step. After 8 iterations (count = 7) the FSM moves to DONE.
  - DONE: copies [19:8] into the committed BCD register, returns to IDLE, and sets busy = 0.
  - load = 1 in SHIFT or DONE restarts the conversion from the new value. Latest load wins; the interrupted value is never committed.
  - Hundreds nibble is never above 2; nibble values above 9 are unreachable and decode to blank.
- Scanner:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - At each wrap the scan index advances 0→1→2→3→0.
  - Index 0 selects ones, 1 selects tens, 2 selects hundreds, 3 drives blank (digit = 7'h7F, display = 4'b0111).
  - The scanner ignores busy and always shows the last committed BCD.
- Decode patterns (active-low): 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.

## Timing
- load sampled at edge k; busy = 1 from k through k+8; commit and busy = 0 at edge k+9. Conversion latency is 9 cycles.
- digit and display are registered from the current scan index and committed BCD, giving 1 cycle of latency.
- A commit changes the digit shown in the current slot starting at the next edge; the slot does not have to finish first.
- Each display position is lit for exactly REFRESH_DIV cycles.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Hundreds digit is blanked (7'h7F) when it is 0.
  - Tens digit is blanked when hundreds and tens are both 0.
  - Ones digit is always shown.
  - The anode for a blanked position still follows the scan pattern.
- Not defined: all three digits are always shown, e.g. 7 displays "007".

## Structure
- Package seg_pkg holds:
  - FSM state enum (IDLE, SHIFT, DONE).
  - SEG_BLANK = 7'h7F.
  - The ten digit segment constants.
  - ANODE_OFF = 4'hF.
- Sub-module bcd_to_seg: combinational 4-bit nibble → 7-bit active-low pattern, with blank for values above 9. It is instantiated once, fed by the scan-index mux.

## Test plan
REFRESH_DIV = 4 for all scenarios.
- Reset: hold clear_n low for 2 cycles → digit = 7F, display = F, busy = 0; after release, slot 0 shows 1000000 with display = 1110.
- load value = 255 → busy high for 9 cycles; then the slots show ones 0010010/1110, tens 0010010/1101, hundreds 0100100/1011, slot 3 7F/0111, each for 4 cycles.
- load value = 7 → with LEADING_ZERO_BLANK_EN: hundreds and tens show 7F, ones shows 1111000; without it: hundreds and tens show 1000000.
- load value = 100, then load value = 42 on the 4th busy cycle → busy stays high for 9 cycles after the second load; display shows 042 (or blank-4-2 with the macro); 100 never appears.
- clear_n low on the 5th busy cycle → next cycle busy = 0, committed BCD = 000, digit = 7F.
- Scan wrap: run 16 cycles → display sequence 1110, 1101, 1011, 0111, repeating, with no skipped or doubled position.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the display scan driver: conversion FSM states,
// active-low segment patterns and the double-dabble step.
package seg_pkg;

  typedef enum logic [1:0] {StIdle, StShift, StDone} conv_state_e;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  localparam logic [3:0] ANODE_OFF = 4'hF;

  // Nibble fed to the decoder to force a blank position.
  localparam logic [3:0] NIB_BLANK = 4'hF;

  // One double-dabble iteration: +3 on each BCD nibble >= 5, then shift left by one.
  function automatic logic [19:0] dabble_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment pattern; values above 9 blank.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_driver.sv
// Binary-to-BCD conversion (one bit per clock) and 4-position multiplexed 7-seg scanning.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module display_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       load,
  input  logic [7:0] value,
  output logic       busy,
  output logic [6:0] digit,
  output logic [3:0] display
);

  localparam logic [15:0] CntMax = 16'(REFRESH_DIV - 1);

  conv_state_e state_q, state_d;
  logic [19:0] shift_q, shift_d;
  logic [2:0]  iter_q, iter_d;
  logic [11:0] bcd_q, bcd_d;

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [6:0]  digit_q;
  logic [3:0]  display_q, display_d;
  logic [3:0]  nib;
  logic [6:0]  seg_pat;

  // Conversion FSM: state register.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
    end
  end

  // Conversion FSM: next state. A load in any state restarts from the new value.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    if (load) begin
      state_d = StShift;
      shift_d = {12'b0, value};
      iter_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StShift: begin
          shift_d = dabble_step(shift_q);
          if (iter_q == 3'd7) begin
            state_d = StDone;
          end else begin
            iter_d = iter_q + 3'd1;
          end
        end
        StDone: begin
          bcd_d   = shift_q[19:8];
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Conversion FSM: outputs.
  always_comb begin
    busy = (state_q != StIdle);
  end

  // Scanner: refresh counter and slot index.
  always_comb begin
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 16'd1;
      idx_d = idx_q;
    end
  end

  always_comb begin
    nib       = NIB_BLANK;
    display_d = ANODE_OFF;
    unique case (idx_q)
      2'd0: begin
        nib       = bcd_q[3:0];
        display_d = 4'b1110;
      end
      2'd1: begin
`ifdef LEADING_ZERO_BLANK_EN
        nib       = (bcd_q[11:4] == 8'd0) ? NIB_BLANK : bcd_q[7:4];
`else
        nib       = bcd_q[7:4];
`endif
        display_d = 4'b1101;
      end
      2'd2: begin
`ifdef LEADING_ZERO_BLANK_EN
        nib       = (bcd_q[11:8] == 4'd0) ? NIB_BLANK : bcd_q[11:8];
`else
        nib       = bcd_q[11:8];
`endif
        display_d = 4'b1011;
      end
      2'd3: begin
        nib       = NIB_BLANK;
        display_d = 4'b0111;
      end
      default: ;
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .nibble (nib),
    .seg    (seg_pat)
  );

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      digit_q   <= SEG_BLANK;
      display_q <= ANODE_OFF;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      digit_q   <= seg_pat;
      display_q <= display_d;
    end
  end

  assign digit   = digit_q;
  assign display = display_q;

endmodule
